// File: rtl/multiplier_inverse_divider_if.sv
// Request/response bundle for the restoring divider: dividend/divisor in,
// quotient/remainder out, each side with its own valid/ready pair.
interface multiplier_inverse_divider_if #(
  parameter int WIDTH = 2
);
  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both 1; the source holds data stable until then, and ready never
  // depends combinationally on valid.
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/multiplier_inverse_divider.sv
// Iterative restoring divider: a 2*WIDTH-bit dividend (e.g. a multiplier
// product) divided by a WIDTH-bit divisor, one quotient bit per CALC cycle.
module multiplier_inverse_divider #(
  parameter int WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  multiplier_inverse_divider_if.slave  bus,
  output logic [1:0]                   o_dbg_state
);

  localparam int DW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [DW-1:0]    r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_accept   = bus.in_valid && (r_state == IDLE);
  assign w_div_zero = (bus.divisor == '0);

  // The held partial remainder is always below the divisor, so it fits in
  // WIDTH bits; only the freshly shifted value needs the extra top bit.
  assign w_shift = {r_rem, r_quo[DW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  assign w_sub   = w_shift[WIDTH-1:0] - r_divisor;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_div_zero ? DONE : CALC;
      CALC:    if (r_cnt == CNT_LAST) w_next_state = DONE;
      DONE:    if (bus.out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divisor <= bus.divisor;
            r_rem     <= '0;
            if (w_div_zero) begin
              r_quo <= '1;
              r_cnt <= '0;
              r_dbz <= 1'b1;
            end else begin
              r_quo <= bus.dividend;
              r_cnt <= CNT_INIT;
              r_dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          r_quo <= {r_quo[DW-2:0], w_ge};
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_cnt <= r_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_multiplier_inverse_divider.sv
// Bench for multiplier_inverse_divider (WIDTH = 2): directed table, reset
// abort sequence, and an exhaustive randomized-gap sweep against a model.
module tb_multiplier_inverse_divider;

  localparam int W  = 2;
  localparam int DW = 2 * W;
  localparam int RW = DW + W + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] exp_q[$];

  multiplier_inverse_divider_if #(.WIDTH(W)) bus ();

  multiplier_inverse_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [DW-1:0] dvd;
    logic [W-1:0]  dvs;
    int            hold;
    logic [DW-1:0] q;
    logic [W-1:0]  r;
    logic          dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic logic [RW-1:0] model(input int dvd, input int dvs);
    logic [DW-1:0] q;
    logic [W-1:0]  r;
    logic          z;
    if (dvs == 0) begin
      q = '1;
      r = '0;
      z = 1'b1;
    end else begin
      q = DW'(dvd / dvs);
      r = W'(dvd % dvs);
      z = 1'b0;
    end
    return {q, r, z};
  endfunction

  // Called on a negedge with the DUT idle or about to be idle; returns on a
  // negedge with the DUT back in IDLE.
  task automatic run_op(input logic [DW-1:0] dvd, input logic [W-1:0] dvs,
                        input int hold, input logic [RW-1:0] expv);
    int            edges;
    int            wait_n;
    logic [RW-1:0] e;
    logic [DW-1:0] eq;
    logic [W-1:0]  er;
    logic          ez;
    exp_q.push_back(expv);
    wait_n = 0;
    while (!bus.in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    while (!bus.out_valid && edges < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.dividend = DW'($urandom);
      bus.divisor  = W'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    e = exp_q.pop_front();
    {eq, er, ez} = e;
    // divide-by-zero reaches DONE on the accept edge itself
    check("latency", 32'(edges), (dvs == 0) ? 32'd0 : 32'(DW));
    check("out_valid", 32'(bus.out_valid), 1);
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    if (dvs != 0) begin
      check("identity", 32'(int'(bus.quotient) * int'(dvs) + int'(bus.remainder)), 32'(dvd));
      check("rem_lt_div", 32'(bus.remainder < dvs), 1);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.dividend = DW'($urandom);
      bus.divisor  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_in_ready", 32'(bus.in_ready), 0);
      check("hold_quotient", 32'(bus.quotient), 32'(eq));
      check("hold_remainder", 32'(bus.remainder), 32'(er));
      check("hold_div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(bus.in_ready), 1);
    check("release_out_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd9,  2'd3, 0, 4'd3,  2'd0, 1'b0};
    vecs[1] = '{4'd15, 2'd2, 0, 4'd7,  2'd1, 1'b0};
    vecs[2] = '{4'd0,  2'd3, 0, 4'd0,  2'd0, 1'b0};
    vecs[3] = '{4'd6,  2'd0, 0, 4'd15, 2'd0, 1'b1};
    vecs[4] = '{4'd14, 2'd3, 5, 4'd4,  2'd2, 1'b0};
    vecs[5] = '{4'd15, 2'd3, 2, 4'd5,  2'd0, 1'b0};
    vecs[6] = '{4'd1,  2'd1, 0, 4'd1,  2'd0, 1'b0};
    vecs[7] = '{4'd7,  2'd0, 3, 4'd15, 2'd0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    // reset state, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_quotient", 32'(bus.quotient), 0);
    check("rst_remainder", 32'(bus.remainder), 0);
    check("rst_div_by_zero", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table; the first row is accepted on the first edge after reset
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].hold, {vecs[i].q, vecs[i].r, vecs[i].dbz});
    end

    // reset pulse during the second CALC cycle aborts the operation
    bus.in_valid  = 1'b1;
    bus.dividend  = 4'd14;
    bus.divisor   = 2'd3;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_in_ready", 32'(bus.in_ready), 1);
    check("abort_quotient", 32'(bus.quotient), 0);
    check("abort_remainder", 32'(bus.remainder), 0);
    check("abort_div_by_zero", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_out_valid", 32'(bus.out_valid), 0);
    end
    bus.out_ready = 1'b0;
    run_op(4'd10, 2'd3, 0, {4'd3, 2'd1, 1'b0});

    // exhaustive sweep with random idle gaps and back-pressure
    for (int dvd = 0; dvd < 16; dvd++) begin
      for (int dvs = 1; dvs < 4; dvs++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_op(DW'(dvd), W'(dvs), int'($urandom_range(0, 3)), model(dvd, dvs));
      end
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
